switch_allocator: RTL
=====================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter MY_X, default 0, this router's mesh X coordinate (2 bits).
REQ-002 Parameter MY_Y, default 0, this router's mesh Y coordinate (2 bits).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high. Ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 north_q_i, south_q_i, east_q_i, west_q_i, local_q_i  input  32 each  input-queue head flits.
REQ-007 mask_i  input  5  per-queue head-valid (1 = non-empty). Index order everywhere: 0=N, 1=S, 2=E, 3=W, 4=L.
REQ-008 pop_req_o  input-queue side, output  5  pop the granted queue head this cycle.
REQ-009 north_o, south_o, east_o, west_o, local_o  output  32 each  registered output flits.
REQ-010 valid_o  output  5  per-output flit valid.
REQ-011 ready_i  input  5  downstream accepts the flit on the matching output this cycle.

Function
REQ-012 Flit format: [31:30] dest X, [29:28] dest Y, [27:0] payload; single-flit packets only.
REQ-013 Route, combinational, XY order: dest X > MY_X -> E; dest X < MY_X -> W; else dest Y > MY_Y -> N; dest Y < MY_Y -> S; else L.
REQ-014 Input i requests output o iff mask_i[i]=1 and route(head i)=o; each input requests at most one output.
REQ-015 Output o is free iff valid_o[o]=0 or ready_i[o]=1.
REQ-016 Each free output with at least one request grants exactly one requester by round-robin, starting the search at that output's pointer.
REQ-017 On grant, pop_req_o[i] SHALL be asserted in the same cycle (combinational); at most one bit per input; never asserted while mask_i[i]=0.
REQ-018 The granted flit SHALL appear on the output with valid_o=1 on the next rising edge; latency is 1 cycle.
REQ-019 If valid_o[o]=1 and ready_i[o]=1 with no new grant, valid_o[o] clears next edge.
REQ-020 If valid_o[o]=1 and ready_i[o]=0, data and valid SHALL hold unchanged and no grant is made to o.
REQ-021 Accept and refill in the same cycle (ready_i=1 plus a grant) SHALL produce back-to-back flits with no bubble; full throughput is 1 flit/cycle/output.
REQ-022 Round-robin pointer of output o updates to (winner+1) mod 5 only on grant; otherwise it holds.
REQ-023 Outputs operate independently; up to 5 grants per cycle.
REQ-024 U-turn routes (e.g. N input routed to N) SHALL be served like any other route.
REQ-025 The payload SHALL pass through unmodified; no flit is dropped or duplicated.

Reset
REQ-026 While rst=1: valid_o=0, all data outputs 0, all pointers 0, pop_req_o forced to 0.
REQ-027 Reset asserted mid-operation SHALL discard held flits immediately (asynchronous); the first grant is allowed on the first clock edge after release.

Structure
REQ-028 Package noc_pkg: FLIT_W=32, NPORTS=5, port index enum (N, S, E, W, L), dest-field bit positions, COORD_W=2.
REQ-029 Sub-module rr_arbiter: 5-bit request, 3-bit pointer in, one-hot grant out, combinational; instantiated once per output.
REQ-030 Pointer and output registers SHALL reside in switch_allocator; routing is a package function.

Verification
REQ-031 MY=(1,1); N head dest (2,1), mask=00001, all ready -> pop_req_o=00001; next cycle east_o=flit, valid_o=00100.
REQ-032 N, S and W all head to L (dest (1,1)) continuously, ready=1 -> local_o grant order N, S, W, N, ... with one flit per cycle.
REQ-033 E output valid, ready_i[2]=0 for 4 cycles with a pending W->E request -> east_o holds, pop_req_o[3]=0; ready rises -> new flit next cycle, no bubble.
REQ-034 Five inputs routed to five distinct outputs in one cycle -> pop_req_o=11111 and valid_o=11111 next cycle.
REQ-035 rst pulse while valid_o=10101 -> valid_o=00000 and pointers=0 without a clock edge; the first post-release grant to L goes to index 0.
REQ-036 Scoreboard under random traffic and random ready: every popped flit appears exactly once on its XY output, per-input order is preserved, and no requester starves for more than 4 grants of its output.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types and the XY routing function used by the switch allocator.
package noc_pkg;

    localparam int FLIT_W  = 32;
    localparam int NPORTS  = 5;
    localparam int COORD_W = 2;
    localparam int PTR_W   = 3;

    localparam int DX_HI = 31;
    localparam int DX_LO = 30;
    localparam int DY_HI = 29;
    localparam int DY_LO = 28;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // Dimension-ordered routing: resolve X first, then Y, then eject locally.
    function automatic port_e xy_route(input logic [FLIT_W-1:0]  flit,
                                       input logic [COORD_W-1:0] my_x,
                                       input logic [COORD_W-1:0] my_y);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = flit[DX_HI:DX_LO];
        dy = flit[DY_HI:DY_LO];
        if (dx > my_x)      return PORT_E;
        else if (dx < my_x) return PORT_W;
        else if (dy > my_y) return PORT_N;
        else if (dy < my_y) return PORT_S;
        else                return PORT_L;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NPORTS-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NPORTS);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// 5-port XY router switch allocator: per-output round-robin grant, one
// registered flit stage per output with ready/valid backpressure.
module switch_allocator
    import noc_pkg::*;
#(
    parameter logic [COORD_W-1:0] MY_X = '0,
    parameter logic [COORD_W-1:0] MY_Y = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] north_q_i,
    input  logic [FLIT_W-1:0] south_q_i,
    input  logic [FLIT_W-1:0] east_q_i,
    input  logic [FLIT_W-1:0] west_q_i,
    input  logic [FLIT_W-1:0] local_q_i,
    input  logic [NPORTS-1:0] mask_i,
    output logic [NPORTS-1:0] pop_req_o,
    output logic [FLIT_W-1:0] north_o,
    output logic [FLIT_W-1:0] south_o,
    output logic [FLIT_W-1:0] east_o,
    output logic [FLIT_W-1:0] west_o,
    output logic [FLIT_W-1:0] local_o,
    output logic [NPORTS-1:0] valid_o,
    input  logic [NPORTS-1:0] ready_i
);

    logic [NPORTS-1:0][FLIT_W-1:0] in_flit;
    logic [NPORTS-1:0][FLIT_W-1:0] out_flit;
    logic [NPORTS-1:0][NPORTS-1:0] req_mat;   // [output][input]
    logic [NPORTS-1:0][NPORTS-1:0] grant;     // [output][input]
    logic [NPORTS-1:0]             free;
    port_e                         dir [NPORTS];

    assign in_flit = {local_q_i, west_q_i, east_q_i, south_q_i, north_q_i};
    assign {local_o, west_o, east_o, south_o, north_o} = out_flit;

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        assign dir[i] = xy_route(in_flit[i], MY_X, MY_Y);
        for (genvar o = 0; o < NPORTS; o++) begin : g_req
            assign req_mat[o][i] = mask_i[i] & (dir[i] == port_e'(o));
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        logic [PTR_W-1:0]  ptr;
        logic [PTR_W-1:0]  win;
        logic [FLIT_W-1:0] sel;
        logic [FLIT_W-1:0] dat_q;
        logic              vld_q;

        // A stalled output is not free, so its requesters stay un-popped.
        assign free[o] = ~vld_q | ready_i[o];

        rr_arbiter u_arb (
            .req   (req_mat[o] & {NPORTS{free[o]}}),
            .ptr   (ptr),
            .grant (grant[o])
        );

        always_comb begin
            win = '0;
            sel = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (grant[o][i]) begin
                    win = PTR_W'(i);
                    sel = in_flit[i];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ptr   <= '0;
                dat_q <= '0;
                vld_q <= 1'b0;
            end else if (|grant[o]) begin
                dat_q <= sel;
                vld_q <= 1'b1;
                ptr   <= (win == PTR_W'(NPORTS - 1)) ? '0 : win + 1'b1;
            end else if (ready_i[o]) begin
                vld_q <= 1'b0;
            end
        end

        assign out_flit[o] = dat_q;
        assign valid_o[o]  = vld_q;
    end

    // Each input routes to exactly one output, so OR-ing grants never
    // yields more than one pop per input.
    always_comb begin
        pop_req_o = '0;
        for (int o = 0; o < NPORTS; o++) pop_req_o |= grant[o];
        if (rst) pop_req_o = '0;
    end

endmodule
